ahb5_traffic_gen: RTL and testbench
===================================

AHB5_TRAFFIC_GEN -- requirements
Module: ahb5_traffic_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width; 32 or 64.
- BASE_ADDR, 32'h80000000, window base; 4 KB aligned.
- WIN_LOG2, 12, window size is 2^WIN_LOG2 bytes; range 3..ADDR_WIDTH-1.
- NUM_TXN, 16, transactions per run; 1..65535.
- SEED, 32'hACE1_0001, LFSR reset value; non-zero.

REQ-002 SHALL have ports (name, direction, width, meaning):
- HCLK, in, 1, clock.
- HRESET, in, 1, reset; synchronous, active-high.
- start, in, 1, run request; sampled in IDLE only.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse when the run ends.
- HADDR, out, ADDR_WIDTH, address.
- HTRANS, out, 2, IDLE=00 or NONSEQ=10 only.
- HWRITE, out, 1, write.
- HSIZE, out, 3, fixed at log2(DATA_WIDTH/8).
- HPROT, out, 4, protection.
- HNONSEC, out, 1, non-secure.
- HWDATA, out, DATA_WIDTH, write data.
- HREADY, in, 1, transfer done.
- HRDATA, in, DATA_WIDTH, read data.
- HRESP, in, 1, error response.
- txn_count, out, 16, completed transfers.
- err_count, out, 16, HRESP errors.
- mis_count, out, 16, readback mismatches.

Function
REQ-003 SHALL use a 32-bit Galois LFSR with taps 32'h80200003, shift right, advancing exactly once per new primary transaction, in the cycle that enters ADDR.
REQ-004 SHALL derive fields from the post-advance LFSR value L:
- HADDR = BASE_ADDR | (L[WIN_LOG2-1:0] with the low log2(DATA_WIDTH/8) bits cleared).
- HWRITE = L[31]; HPROT = L[27:24]; HNONSEC = L[23].
- Write data = {DATA_WIDTH/32 copies of (L ^ HADDR[31:0])}.
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA, RB_ADDR, RB_DATA, FIN.
REQ-006 IDLE: HTRANS=00; on start=1 go to ADDR, clear all three counters, set busy.
REQ-007 ADDR: HTRANS=10 with address/control held stable; go to DATA on the first HREADY=1 edge.
REQ-008 DATA: HTRANS=00; HWDATA held if a write; stay until HREADY=1.
REQ-009 On DATA completion:
- txn_count += 1.
- err_count += 1 if HRESP=1.
- Next state is RB_ADDR per REQ-015; otherwise ADDR if txn_count+1 < NUM_TXN, else FIN.
REQ-010 HRESP=1 with HREADY=0 (first error cycle) SHALL NOT change state or counters; only the HREADY=1 cycle is counted.
REQ-011 FIN: deassert busy, pulse done for one cycle, return to IDLE.
REQ-012 start during any non-IDLE state SHALL be ignored.
REQ-013 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-014 Outputs SHALL be registered; the first NONSEQ appears the cycle after start is sampled.

Reset
REQ-016 HRESET=1 at a clock edge SHALL force IDLE and LFSR=SEED, and set:
- busy=0, done=0, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, HPROT=0, HNONSEC=0.
- txn_count=0, err_count=0, mis_count=0.
REQ-017 Reset during ADDR/DATA/RB_* SHALL abandon the transfer immediately, with no done pulse and no counter update.

Configuration
REQ-015 Macro AHB_TG_READBACK_EN:
- Defined: a write completing with HRESP=0 SHALL be followed by RB_ADDR (NONSEQ read, same HADDR/HPROT/HNONSEC, LFSR not advanced), then RB_DATA.
- RB_DATA completion: mis_count += 1 if HRDATA differs from the written data; err_count += 1 if HRESP=1; txn_count is not incremented.
- RB_DATA then proceeds as REQ-009's non-readback path.
- Undefined: RB states, readback logic and mis_count logic are absent; mis_count is tied to 0.

Verification
REQ-018 Reset, SEED default, start pulse, HREADY=1 always -> first HADDR = 32'h80000000 | (L[11:0]&~3) with L = one LFSR step of 32'hACE10001; done after NUM_TXN transfers; txn_count=16.
REQ-019 HREADY=0 for 3 cycles in ADDR and in DATA -> HADDR/HTRANS/HWDATA held stable; txn_count increments only once.
REQ-020 Slave gives two-cycle error (HREADY=0,HRESP=1 then HREADY=1,HRESP=1) on every 4th transfer, NUM_TXN=16 -> err_count=4, txn_count=16.
REQ-021 AHB_TG_READBACK_EN defined, memory model corrupting bit 0 on the 2nd write -> mis_count=1; every write is followed by a read to the same address.
REQ-022 HRESET asserted mid-DATA, then released and start reissued -> no done pulse before the reissue; the LFSR sequence restarts from SEED (first HADDR identical to REQ-018).

Source files
------------

// File: rtl/ahb5_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_traffic_gen
// Description : Single-outstanding AHB5 manager that issues NUM_TXN
//               pseudo-random NONSEQ transfers into a 2^WIN_LOG2-byte window
//               at BASE_ADDR. Address, direction, HPROT, HNONSEC and write
//               data are all taken from a 32-bit Galois LFSR. Completed
//               transfers and error responses are counted with saturation.
//               Optional macro AHB_TG_READBACK_EN: every error-free write is
//               followed by a read of the same location, and read data that
//               differs from the written data increments mis_count.
//               Without the macro mis_count is tied to zero.
// Ports       : HCLK, HRESET (sync, active-high)
//               start        - run request, sampled in IDLE only
//               busy, done   - run in progress / one-cycle end-of-run pulse
//               HADDR, HTRANS, HWRITE, HSIZE, HPROT, HNONSEC, HWDATA
//                            - registered AHB manager outputs
//               HREADY, HRDATA, HRESP - AHB subordinate response
//               txn_count, err_count, mis_count - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module ahb5_traffic_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    WIN_LOG2   = 12,
    parameter int                    NUM_TXN    = 16,
    parameter logic [31:0]           SEED       = 32'hACE1_0001
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [3:0]            HPROT,
    output logic                  HNONSEC,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HRESP,
    output logic [15:0]           txn_count,
    output logic [15:0]           err_count,
    output logic [15:0]           mis_count
);

    localparam int                    c_lane_log2 = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]            c_hsize     = 3'(c_lane_log2);
    localparam logic [ADDR_WIDTH-1:0] c_win_mask  = ADDR_WIDTH'((64'd1 << WIN_LOG2) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] c_lane_mask = ADDR_WIDTH'((64'd1 << c_lane_log2) - 64'd1);
    // Window offset bits with the byte-lane bits cleared (size-aligned).
    localparam logic [ADDR_WIDTH-1:0] c_off_mask  = c_win_mask & ~c_lane_mask;
    localparam logic [31:0]           c_taps      = 32'h8020_0003;
    localparam logic [16:0]           c_num_txn   = 17'(NUM_TXN);
    localparam logic [1:0]            c_htrans_idle   = 2'b00;
    localparam logic [1:0]            c_htrans_nonseq = 2'b10;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_addr    = 3'd1;
    localparam logic [2:0] c_st_data    = 3'd2;
`ifdef AHB_TG_READBACK_EN
    localparam logic [2:0] c_st_rb_addr = 3'd3;
    localparam logic [2:0] c_st_rb_data = 3'd4;
`endif
    localparam logic [2:0] c_st_fin     = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [31:0]           r_lfsr;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [3:0]            r_hprot;
    logic                  r_hnonsec;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [15:0]           r_txn_count;
    logic [15:0]           r_err_count;

    logic [31:0]           w_lfsr_step;
    logic [ADDR_WIDTH-1:0] w_new_haddr;
    logic [31:0]           w_new_word;
    logic [DATA_WIDTH-1:0] w_new_wdata;
    logic                  w_more_after_data;
    logic                  w_issue;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Galois LFSR, shift right: feedback taps applied when bit 0 falls out.
    assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_taps : 32'h0);
    assign w_new_haddr = BASE_ADDR | (ADDR_WIDTH'(w_lfsr_step) & c_off_mask);
    assign w_new_word  = w_lfsr_step ^ 32'(w_new_haddr);
    assign w_new_wdata = {(DATA_WIDTH / 32){w_new_word}};

    // The counter still holds the pre-increment value when the data phase ends.
    assign w_more_after_data = (({1'b0, r_txn_count} + 17'd1) < c_num_txn);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start)  w_state_nxt = c_st_addr;
            c_st_addr: if (HREADY) w_state_nxt = c_st_data;
            c_st_data: begin
                if (HREADY) begin
`ifdef AHB_TG_READBACK_EN
                    if (r_hwrite && !HRESP)
                        w_state_nxt = c_st_rb_addr;
                    else
`endif
                    w_state_nxt = w_more_after_data ? c_st_addr : c_st_fin;
                end
            end
`ifdef AHB_TG_READBACK_EN
            c_st_rb_addr: if (HREADY) w_state_nxt = c_st_rb_data;
            c_st_rb_data: begin
                // txn_count already includes the write being verified.
                if (HREADY)
                    w_state_nxt = ({1'b0, r_txn_count} < c_num_txn) ? c_st_addr : c_st_fin;
            end
`endif
            c_st_fin: w_state_nxt = c_st_idle;
            default:  w_state_nxt = c_st_idle;
        endcase
    end

    // A new primary transfer starts on every entry into ADDR.
    assign w_issue = (w_state_nxt == c_st_addr) && (r_state != c_st_addr);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= c_st_idle;
            r_lfsr      <= SEED;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_haddr     <= '0;
            r_htrans    <= c_htrans_idle;
            r_hwrite    <= 1'b0;
            r_hprot     <= 4'h0;
            r_hnonsec   <= 1'b0;
            r_hwdata    <= '0;
            r_wdata     <= '0;
            r_txn_count <= 16'h0;
            r_err_count <= 16'h0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;

            if (w_issue) begin
                r_lfsr    <= w_lfsr_step;
                r_htrans  <= c_htrans_nonseq;
                r_haddr   <= w_new_haddr;
                r_hwrite  <= w_lfsr_step[31];
                r_hprot   <= w_lfsr_step[27:24];
                r_hnonsec <= w_lfsr_step[23];
                r_wdata   <= w_new_wdata;
            end

            if ((w_state_nxt == c_st_fin) && (r_state != c_st_fin)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_txn_count <= 16'h0;
                        r_err_count <= 16'h0;
                    end
                end
                c_st_addr: begin
                    if (HREADY) begin
                        r_htrans <= c_htrans_idle;
                        if (r_hwrite) r_hwdata <= r_wdata;
                    end
                end
                c_st_data: begin
                    if (HREADY) begin
                        r_txn_count <= sat_inc(r_txn_count);
                        if (HRESP) r_err_count <= sat_inc(r_err_count);
`ifdef AHB_TG_READBACK_EN
                        if (w_state_nxt == c_st_rb_addr) begin
                            // Same address/HPROT/HNONSEC, read direction.
                            r_htrans <= c_htrans_nonseq;
                            r_hwrite <= 1'b0;
                        end
`endif
                    end
                end
`ifdef AHB_TG_READBACK_EN
                c_st_rb_addr: if (HREADY) r_htrans <= c_htrans_idle;
                c_st_rb_data: if (HREADY && HRESP) r_err_count <= sat_inc(r_err_count);
`endif
                default: ;
            endcase
        end
    end

`ifdef AHB_TG_READBACK_EN
    logic [15:0] r_mis_count;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_mis_count <= 16'h0;
        end else if ((r_state == c_st_idle) && start) begin
            r_mis_count <= 16'h0;
        end else if ((r_state == c_st_rb_data) && HREADY && (HRDATA != r_wdata)) begin
            r_mis_count <= sat_inc(r_mis_count);
        end
    end

    assign mis_count = r_mis_count;
`else
    // Read data is never inspected in this build.
    logic w_unused_rdata;
    assign w_unused_rdata = ^HRDATA;
    assign mis_count      = 16'h0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = c_hsize;
    assign HPROT     = r_hprot;
    assign HNONSEC   = r_hnonsec;
    assign HWDATA    = r_hwdata;
    assign txn_count = r_txn_count;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ahb5_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb5_traffic_gen
// Description : Bench for ahb5_traffic_gen with default parameters. A small
//               reference LFSR predicts every transfer into a scoreboard
//               queue when a run is launched; a monitor pops and compares on
//               each NONSEQ address phase and checks data-phase HWDATA and
//               live counters. A reactive subordinate model provides wait
//               states, two-cycle errors and a memory (optionally corrupting
//               the 2nd write). Honours AHB_TG_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb5_traffic_gen;

    localparam int c_num_txn = 16;

    logic        HCLK;
    logic        HRESET;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HNONSEC;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [15:0] txn_count;
    logic [15:0] err_count;
    logic [15:0] mis_count;

    ahb5_traffic_gen dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HNONSEC   (HNONSEC),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .txn_count (txn_count),
        .err_count (err_count),
        .mis_count (mis_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  prot;
        logic        ns;
        logic [31:0] wdata;
        logic        rb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // ---------------- subordinate model ----------------
    int          mode = 0;          // 0: zero wait, 1: 3 waits addr+data, 2: error every 4th
    bit          rb_corrupt = 1'b0;
    int          xfer_idx = 0;
    int          wr_cnt = 0;
    logic [31:0] mem [logic [31:0]];

    initial begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
    end

    always begin : slave
        bit          acc_addr, acc_data, in_dph, d_wr, d_err, a_active;
        logic [31:0] cap_addr, cap_wdata, d_addr;
        logic        cap_wr;
        int          d_wait, a_wait;
        in_dph = 0; a_active = 0; d_wait = 0; a_wait = 0;
        d_wr = 0; d_err = 0; d_addr = '0;
        forever begin
            @(negedge HCLK);
            acc_addr  = !HRESET && (HTRANS == 2'b10) && HREADY;
            acc_data  = !HRESET && in_dph && HREADY;
            cap_addr  = HADDR;
            cap_wr    = HWRITE;
            cap_wdata = HWDATA;
            @(posedge HCLK);
            #1;
            if (HRESET) begin
                in_dph = 0; a_active = 0;
                HREADY = 1'b1; HRESP = 1'b0;
            end else begin
                if (acc_data) begin
                    if (d_wr && !d_err) begin
                        wr_cnt++;
                        mem[d_addr] = (rb_corrupt && wr_cnt == 2) ? (cap_wdata ^ 32'h1) : cap_wdata;
                    end
                    in_dph = 0;
                end
                if (acc_addr) begin
                    in_dph   = 1; a_active = 0;
                    d_addr   = cap_addr; d_wr = cap_wr;
                    d_err    = (mode == 2) && (xfer_idx % 4 == 3);
                    d_wait   = (mode == 1) ? 3 : (d_err ? 1 : 0);
                    xfer_idx++;
                end
                if (in_dph) begin
                    HRESP = d_err;
                    if (d_wait > 0) begin
                        HREADY = 1'b0; d_wait--;
                    end else begin
                        HREADY = 1'b1;
                        HRDATA = mem.exists(d_addr) ? mem[d_addr] : 32'h0;
                    end
                end else begin
                    HRESP = 1'b0;
                    if (HTRANS == 2'b10) begin
                        if (!a_active) begin
                            a_active = 1;
                            a_wait   = (mode == 1) ? 3 : 0;
                        end
                        if (a_wait > 0) begin
                            HREADY = 1'b0; a_wait--;
                        end else begin
                            HREADY = 1'b1;
                        end
                    end else begin
                        HREADY = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          exp_txn = 0;
    int          exp_err = 0;
    int          done_cnt = 0;
    bit          a_seen = 0;
    bit          d_pending = 0;
    exp_t        cur;
    logic [31:0] held_addr;
    logic        held_wr;

    always @(negedge HCLK) begin : monitor
        if (HRESET) begin
            a_seen = 0; d_pending = 0;
        end else begin
            if (done) done_cnt++;
            if (busy) begin
                chk("txn_count_live", 64'(txn_count), 64'(exp_txn));
                chk("err_count_live", 64'(err_count), 64'(exp_err));
            end
            if (HTRANS == 2'b10) begin
                if (!a_seen) begin
                    if (sb_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL sb_underflow: unexpected NONSEQ addr %0h", HADDR);
                        cur.wr = 1'b0; cur.rb = 1'b1;
                    end else begin
                        cur = sb_q.pop_front();
                        chk("haddr",   64'(HADDR),   64'(cur.addr));
                        chk("hwrite",  64'(HWRITE),  64'(cur.wr));
                        chk("hprot",   64'(HPROT),   64'(cur.prot));
                        chk("hnonsec", 64'(HNONSEC), 64'(cur.ns));
                        chk("hsize",   64'(HSIZE),   64'd2);
                    end
                    a_seen = 1; held_addr = HADDR; held_wr = HWRITE;
                end else begin
                    chk("haddr_hold",  64'(HADDR),  64'(held_addr));
                    chk("hwrite_hold", 64'(HWRITE), 64'(held_wr));
                end
                if (HREADY) begin
                    a_seen = 0; d_pending = 1;
                end
            end else if (d_pending) begin
                if (cur.wr) chk("hwdata", 64'(HWDATA), 64'(cur.wdata));
                if (HREADY) begin
                    d_pending = 0;
                    if (!cur.rb) exp_txn++;
                    if (HRESP) exp_err++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge HCLK);
        chk({tag, "_busy"},    64'(busy),      64'd0);
        chk({tag, "_done"},    64'(done),      64'd0);
        chk({tag, "_htrans"},  64'(HTRANS),    64'd0);
        chk({tag, "_haddr"},   64'(HADDR),     64'd0);
        chk({tag, "_hwrite"},  64'(HWRITE),    64'd0);
        chk({tag, "_hwdata"},  64'(HWDATA),    64'd0);
        chk({tag, "_hprot"},   64'(HPROT),     64'd0);
        chk({tag, "_hnonsec"}, 64'(HNONSEC),   64'd0);
        chk({tag, "_txn"},     64'(txn_count), 64'd0);
        chk({tag, "_err"},     64'(err_count), 64'd0);
        chk({tag, "_mis"},     64'(mis_count), 64'd0);
    endtask

    // Launch a run from a freshly reset generator (LFSR = SEED).
    task automatic launch(input int mode_i, input bit corrupt);
        logic [31:0] l;
        exp_t        e;
        mode = mode_i; rb_corrupt = corrupt;
        xfer_idx = 0; wr_cnt = 0; mem.delete();
        sb_q.delete();
        exp_txn = 0; exp_err = 0;
        l = 32'hACE1_0001;
        for (int i = 0; i < c_num_txn; i++) begin
            l       = lfsr_next(l);
            e.addr  = 32'h8000_0000 | (l & 32'h0000_0FFC);
            e.wr    = l[31];
            e.prot  = l[27:24];
            e.ns    = l[23];
            e.wdata = l ^ e.addr;
            e.rb    = 1'b0;
            sb_q.push_back(e);
`ifdef AHB_TG_READBACK_EN
            // Error injection is not combined with readback runs.
            if (e.wr) begin
                e.wr = 1'b0; e.rb = 1'b1;
                sb_q.push_back(e);
            end
`endif
        end
        @(posedge HCLK); #1;
        start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        // First NONSEQ one cycle after start is sampled; L = 32'hD6508003.
        @(negedge HCLK);
        chk("first_htrans",  64'(HTRANS),  64'h2);
        chk("first_busy",    64'(busy),    64'd1);
        chk("first_haddr",   64'(HADDR),   64'h8000_0000);
        chk("first_hwrite",  64'(HWRITE),  64'd1);
        chk("first_hprot",   64'(HPROT),   64'h6);
        chk("first_hnonsec", 64'(HNONSEC), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int e_txn, input int e_err, input int e_mis);
        bit got;
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge HCLK);
            if (done) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got no done expected done within 3000 cycles", tag);
        end else begin
            chk({tag, "_busy_at_done"}, 64'(busy),      64'd0);
            chk({tag, "_txn"},          64'(txn_count), 64'(e_txn));
            chk({tag, "_err"},          64'(err_count), 64'(e_err));
            chk({tag, "_mis"},          64'(mis_count), 64'(e_mis));
            chk({tag, "_sb_left"},      64'(sb_q.size()), 64'd0);
            @(negedge HCLK);
            chk({tag, "_done_pulse"},   64'(done),      64'd0);
            chk({tag, "_idle_htrans"},  64'(HTRANS),    64'd0);
        end
    endtask

    initial begin : main
        int  dc;
        bit  hit;
        HRESET = 1'b1;
        start  = 1'b0;
        do_reset();
        check_reset_state("rst");

        // Zero-wait run with a stray start mid-run that must be ignored.
        launch(0, 0);
        repeat (5) @(posedge HCLK);
        #1; start = 1'b1;
        @(posedge HCLK); #1; start = 1'b0;
        wait_done("basic", 16, 0, 0);

        // Wait states in both address and data phase.
        do_reset();
        launch(1, 0);
        wait_done("waits", 16, 0, 0);

`ifndef AHB_TG_READBACK_EN
        // Two-cycle error on every 4th transfer.
        do_reset();
        launch(2, 0);
        wait_done("errors", 16, 4, 0);
`else
        // Memory corrupts bit 0 of the 2nd stored write.
        do_reset();
        launch(0, 1);
        wait_done("readback", 16, 0, 1);
`endif

        // Reset in the data phase of the 3rd transfer, then restart.
        do_reset();
        launch(1, 0);
        hit = 0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge HCLK);
            if (busy && HTRANS == 2'b00 && txn_count == 16'd2) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL abort_reach: got no 3rd data phase expected one within 500 cycles");
        end
        dc = done_cnt;
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1; HRESET = 1'b0;
        check_reset_state("abort");
        chk("abort_no_done", 64'(done_cnt), 64'(dc));
        launch(0, 0);
        wait_done("restart", 16, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
